// File: rtl/bopit_round_ctrl.sv
// rtl/bopit_round_ctrl.sv - Bop-it round sequencer: command issue, countdown, scoring
// A pseudo-random command is issued each round; the window shrinks every STEP_HITS hits.
module bopit_round_ctrl #(
  parameter int TICK_DIV  = 100000000,
  parameter int WIN_START = 5,
  parameter int WIN_MIN   = 1,
  parameter int STEP_HITS = 5,
  parameter int MAX_SCORE = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] act,
  output logic [1:0] cmd,
  output logic [6:0] score,
  output logic [6:0] hi_score,
  output logic [3:0] time_left,
  output logic [2:0] state_o,
  output logic       game_over,
  output logic       flash
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(STEP_HITS + 1);
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [3:0]    WIN_START_L = 4'(WIN_START);
  localparam logic [3:0]    WIN_MIN_L   = 4'(WIN_MIN);
  localparam logic [HW-1:0] STEP_L      = HW'(STEP_HITS);
  localparam logic [6:0]    MAX_L       = 7'(MAX_SCORE);

  state_t        state_q, state_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [6:0]    score_q, score_d, hi_q, hi_d, score_inc;
  logic [3:0]    tl_q, tl_d, win_q, win_d;
  logic [HW-1:0] hits_q, hits_d, hits_inc;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          over_q, over_d, flash_q, flash_d;
  logic          start_q, start_prev_q;
  logic [2:0]    act_q, act_prev_q;
  logic          tick, start_edge, hit, miss, new_game;
  logic [2:0]    act_edge, cmd_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cmd_q        <= 2'd3;
      score_q      <= '0;
      hi_q         <= '0;
      tl_q         <= '0;
      win_q        <= WIN_START_L;
      hits_q       <= '0;
      tick_cnt_q   <= '0;
      lfsr_q       <= 16'hACE1;
      over_q       <= 1'b0;
      flash_q      <= 1'b0;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      act_q        <= '0;
      act_prev_q   <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      score_q      <= score_d;
      hi_q         <= hi_d;
      tl_q         <= tl_d;
      win_q        <= win_d;
      hits_q       <= hits_d;
      tick_cnt_q   <= tick_cnt_d;
      lfsr_q       <= lfsr_d;
      over_q       <= over_d;
      flash_q      <= flash_d;
      start_q      <= start;
      start_prev_q <= start_q;
      act_q        <= act;
      act_prev_q   <= act_q;
    end
  end

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    start_edge = start_q & ~start_prev_q;
    act_edge   = act_q & ~act_prev_q;
    // cmd=3 shifts the bit out, so every edge counts as wrong outside a valid command
    cmd_mask   = 3'b001 << cmd_q;
    hit        = |(act_edge & cmd_mask);
    miss       = |(act_edge & ~cmd_mask);
    score_inc  = (score_q == MAX_L) ? score_q : score_q + 7'd1;
    hits_inc   = hits_q + 1'b1;

    lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    tick_cnt_d = (tick || state_q == S_ISSUE) ? '0 : tick_cnt_q + 1'b1;

    state_d  = state_q;
    cmd_d    = cmd_q;
    score_d  = score_q;
    hi_d     = hi_q;
    tl_d     = tl_q;
    win_d    = win_q;
    hits_d   = hits_q;
    over_d   = 1'b0;
    flash_d  = 1'b0;
    new_game = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_d    = 2'd3;
        new_game = start_edge;
      end
      S_ISSUE: begin
        cmd_d   = (lfsr_q[1:0] == 2'd3) ? 2'd0 : lfsr_q[1:0];
        tl_d    = win_q;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (miss) begin
          cmd_d   = 2'd3;
          state_d = S_OVER;
          over_d  = 1'b1;
        end else if (hit) begin
          score_d = score_inc;
          cmd_d   = 2'd3;
          if (hits_inc == STEP_L) begin
            hits_d = '0;
            win_d  = (win_q > WIN_MIN_L) ? win_q - 4'd1 : WIN_MIN_L;
          end else begin
            hits_d = hits_inc;
          end
          if (score_inc == MAX_L) begin
            state_d = S_OVER;
            over_d  = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end else if (tick) begin
          if (tl_q == 4'd1) begin
            tl_d    = 4'd0;
            cmd_d   = 2'd3;
            state_d = S_OVER;
            over_d  = 1'b1;
          end else begin
            tl_d = tl_q - 4'd1;
          end
        end
      end
      S_GAP: begin
        cmd_d = 2'd3;
        if (tick) state_d = S_ISSUE;
      end
      S_OVER: begin
        cmd_d   = 2'd3;
        flash_d = flash_q ^ tick;
        if (over_q && score_q > hi_q) hi_d = score_q;
        new_game = start_edge;
      end
      default: begin
        cmd_d   = 2'd3;
        state_d = S_IDLE;
      end
    endcase

    if (new_game) begin
      score_d = '0;
      win_d   = WIN_START_L;
      hits_d  = '0;
      flash_d = 1'b0;
      state_d = S_ISSUE;
    end
  end

  assign cmd       = cmd_q;
  assign score     = score_q;
  assign hi_score  = hi_q;
  assign time_left = tl_q;
  assign state_o   = state_q;
  assign game_over = over_q;
  assign flash     = flash_q;

endmodule

// File: tb/tb_bopit_round_ctrl.sv
// tb/tb_bopit_round_ctrl.sv - directed bench for bopit_round_ctrl
// Two instances: default build and a MAX_SCORE=3 build selected through shared stimulus.
module tb_bopit_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst2, start_drv, sel;
  logic [2:0] act_drv;
  logic       start1, start2;
  logic [2:0] act1, act2;

  logic [1:0] cmd1, cmd2;
  logic [6:0] score1, score2, hi1, hi2;
  logic [3:0] tl1, tl2;
  logic [2:0] st1, st2;
  logic       go1, go2, fl1, fl2;

  assign start1 = sel ? 1'b0 : start_drv;
  assign start2 = sel ? start_drv : 1'b0;
  assign act1   = sel ? 3'b000 : act_drv;
  assign act2   = sel ? act_drv : 3'b000;

  logic [1:0] cmd_w;
  logic [6:0] score_w, hi_w;
  logic [3:0] tl_w;
  logic [2:0] st_w;
  logic       go_w, fl_w;
  assign cmd_w   = sel ? cmd2 : cmd1;
  assign score_w = sel ? score2 : score1;
  assign hi_w    = sel ? hi2 : hi1;
  assign tl_w    = sel ? tl2 : tl1;
  assign st_w    = sel ? st2 : st1;
  assign go_w    = sel ? go2 : go1;
  assign fl_w    = sel ? fl2 : fl1;

  bopit_round_ctrl #(.TICK_DIV(4), .WIN_START(5), .WIN_MIN(1), .STEP_HITS(5), .MAX_SCORE(99)) dut (
    .clk(clk), .rst(rst), .start(start1), .act(act1), .cmd(cmd1), .score(score1),
    .hi_score(hi1), .time_left(tl1), .state_o(st1), .game_over(go1), .flash(fl1)
  );

  bopit_round_ctrl #(.TICK_DIV(4), .WIN_START(5), .WIN_MIN(1), .STEP_HITS(5), .MAX_SCORE(3)) dut_max3 (
    .clk(clk), .rst(rst2), .start(start2), .act(act2), .cmd(cmd2), .score(score2),
    .hi_score(hi2), .time_left(tl2), .state_o(st2), .game_over(go2), .flash(fl2)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  logic [15:0] m1, m2;
  always @(posedge clk) begin
    m1 <= rst  ? 16'hACE1 : lfsr_next(m1);
    m2 <= rst2 ? 16'hACE1 : lfsr_next(m2);
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] onehot(input int b);
    logic [2:0] v;
    v = 3'b000;
    v[b] = 1'b1;
    return v;
  endfunction

  task automatic wait_state(input int s, input int budget);
    int n = 0;
    while (int'(st_w) != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (int'(st_w) != s) chk("wait_state", int'(st_w), s);
  endtask

  task automatic start_pulse();
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
  endtask

  // mode: 0 correct early, 1 correct landing on the tick, 2 wrong, 3 correct+wrong, 4 no press
  task automatic round(input int mode, input int exp_tl, input int exp_score, input int exp_st);
    logic [15:0] mv;
    int ec;
    wait_state(1, 12);
    mv = sel ? m2 : m1;
    ec = (mv[1:0] == 2'd3) ? 0 : int'(mv[1:0]);
    @(negedge clk);
    chk("round_state", int'(st_w), 2);
    chk("round_cmd", int'(cmd_w), ec);
    chk("round_tl", int'(tl_w), exp_tl);
    if (mode == 4) return;
    if (mode == 1) begin
      @(negedge clk);
      @(negedge clk);
    end
    case (mode)
      2:       act_drv = onehot((ec + 1) % 3);
      3:       act_drv = onehot(ec) | onehot((ec + 2) % 3);
      default: act_drv = onehot(ec);
    endcase
    @(negedge clk);
    act_drv = 3'b000;
    @(negedge clk);
    chk("after_state", int'(st_w), exp_st);
    chk("after_score", int'(score_w), exp_score);
    chk("after_tl", int'(tl_w), exp_tl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    sel = 1'b0; rst = 1'b1; rst2 = 1'b1; start_drv = 1'b0; act_drv = 3'b000;
    repeat (3) @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    chk("rst_cmd", int'(cmd1), 3);
    chk("rst_score", int'(score1), 0);
    chk("rst_hi", int'(hi1), 0);
    chk("rst_tl", int'(tl1), 0);
    chk("rst_state", int'(st1), 0);
    chk("rst_go", int'(go1), 0);
    chk("rst_flash", int'(fl1), 0);
    chk("rst_state2", int'(st2), 0);

    // timeout game
    start_pulse();
    chk("start_lat1", int'(st_w), 0);
    @(negedge clk);
    chk("start_lat2", int'(st_w), 1);
    round(4, 5, 0, 2);
    for (int k = 1; k <= 20; k++) begin
      if (k % 4 == 1) chk("tl_countdown", int'(tl_w), 5 - k / 4);
      @(negedge clk);
    end
    chk("to_state", int'(st_w), 4);
    chk("to_tl", int'(tl_w), 0);
    chk("to_go", int'(go_w), 1);
    chk("to_cmd", int'(cmd_w), 3);
    chk("to_flash0", int'(fl_w), 0);
    @(negedge clk);
    chk("to_go_pulse", int'(go_w), 0);
    chk("to_hi", int'(hi_w), 0);
    repeat (3) @(negedge clk);
    chk("to_flash1", int'(fl_w), 1);

    // 25 hits, last five landing on the tick at time_left=1, then a wrong press
    start_pulse();
    for (int r = 1; r <= 25; r++) begin
      int w;
      w = 5 - (r - 1) / 5;
      if (w < 1) w = 1;
      round((r > 20) ? 1 : 0, w, r, 3);
    end
    round(2, 1, 25, 4);
    @(negedge clk);
    chk("miss_hi", int'(hi_w), 25);
    chk("miss_score_held", int'(score_w), 25);

    // correct and wrong together at score 7
    start_pulse();
    for (int r = 1; r <= 7; r++) round(0, (r > 5) ? 4 : 5, r, 3);
    round(3, 4, 7, 4);
    @(negedge clk);
    chk("both_hi_kept", int'(hi_w), 25);

    // reset mid-WAIT at score 7; stray start edge is ignored first
    start_pulse();
    for (int r = 1; r <= 7; r++) round(0, (r > 5) ? 4 : 5, r, 3);
    round(4, 4, 7, 2);
    chk("wait_score7", int'(score_w), 7);
    start_pulse();
    @(negedge clk);
    chk("start_ignored", int'(st_w), 2);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_state", int'(st_w), 0);
    chk("mid_rst_score", int'(score_w), 0);
    chk("mid_rst_hi", int'(hi_w), 0);
    chk("mid_rst_cmd", int'(cmd_w), 3);
    chk("mid_rst_tl", int'(tl_w), 0);
    rst = 1'b0;
    @(negedge clk);

    // MAX_SCORE=3 build
    sel = 1'b1;
    @(negedge clk);
    start_pulse();
    round(0, 5, 1, 3);
    round(0, 5, 2, 3);
    round(0, 5, 3, 4);
    @(negedge clk);
    chk("max_hi", int'(hi_w), 3);
    start_pulse();
    round(4, 5, 0, 2);
    chk("max_restart_score", int'(score_w), 0);
    chk("max_restart_hi", int'(hi_w), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
